// File: rtl/sequencer_pkg.sv
// Shared constants for the program sequencer: opcodes, register transfer
// codes, ALU selects and the sequencer state encoding.
package sequencer_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDX  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_MOVZ = 4'h4;
    localparam logic [3:0] OP_CLR  = 4'h5;
    localparam logic [3:0] OP_SHRY = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_REP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] T_HOLD  = 2'b00;
    localparam logic [1:0] T_LOAD  = 2'b01;
    localparam logic [1:0] T_CLEAR = 2'b10;
    localparam logic [1:0] T_SHR   = 2'b11;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_EXEC  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/program_sequencer_instr_decoder.sv
// Combinational opcode decoder: register/ALU controls plus control-flow
// classification. Opcodes A..E are undefined and decode as NOP + illegal.
module instr_decoder
    import sequencer_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [1:0] tx,
    output logic [1:0] ty,
    output logic [1:0] tz,
    output logic       talu,
    output logic       is_jmp,
    output logic       is_jz,
    output logic       is_rep,
    output logic       is_halt,
    output logic       is_illegal
);

    // Map the opcode onto control codes; everything defaults to HOLD / no action
    always_comb begin
        tx         = T_HOLD;
        ty         = T_HOLD;
        tz         = T_HOLD;
        talu       = ALU_ADD;
        is_jmp     = 1'b0;
        is_jz      = 1'b0;
        is_rep     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_NOP:  tx = T_HOLD;
            OP_LDX:  tx = T_LOAD;
            OP_ADD:  begin
                talu = ALU_ADD;
                ty   = T_LOAD;
            end
            OP_SUB:  begin
                talu = ALU_SUB;
                ty   = T_LOAD;
            end
            OP_MOVZ: tz = T_LOAD;
            OP_CLR:  begin
                tx = T_CLEAR;
                ty = T_CLEAR;
                tz = T_CLEAR;
            end
            OP_SHRY: ty = T_SHR;
            OP_JMP:  is_jmp = 1'b1;
            OP_JZ:   is_jz = 1'b1;
            OP_REP:  is_rep = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/program_sequencer.sv
// Instruction sequencer: fetch / latch / execute loop over a synchronous
// program ROM, with jumps, zero branch, hardware repeat and halt.
module program_sequencer
    import sequencer_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    input  logic               y_zero,
    output logic [ADDR_W-1:0]  pc,
    output logic [1:0]         Tx,
    output logic [1:0]         Ty,
    output logic [1:0]         Tz,
    output logic               Talu,
    output logic               busy,
    output logic               done,
    output logic               illegal
);

    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ZERO_A  = {ADDR_W{1'b0}};

    seq_state_e         state_r, state_s;
    logic [ADDR_W-1:0]  pc_r, pc_s;
    logic [INSTR_W-1:0] ir_r, ir_s;
    logic [ADDR_W-1:0]  rep_cnt_r, rep_cnt_s;
    logic               done_r, done_s;
    logic               illegal_r, illegal_s;

    logic [3:0]         opcode_s;
    logic [ADDR_W-1:0]  operand_s;
    logic [1:0]         dec_tx_s, dec_ty_s, dec_tz_s;
    logic               dec_talu_s;
    logic               dec_jmp_s, dec_jz_s, dec_rep_s, dec_halt_s, dec_illegal_s;

    assign opcode_s  = ir_r[INSTR_W-1:INSTR_W-4];
    assign operand_s = ir_r[ADDR_W-1:0];

    instr_decoder u_decoder (
        .opcode     (opcode_s),
        .tx         (dec_tx_s),
        .ty         (dec_ty_s),
        .tz         (dec_tz_s),
        .talu       (dec_talu_s),
        .is_jmp     (dec_jmp_s),
        .is_jz      (dec_jz_s),
        .is_rep     (dec_rep_s),
        .is_halt    (dec_halt_s),
        .is_illegal (dec_illegal_s)
    );

    // Next-state logic for the FSM, pc, ir, repeat counter and flags
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        ir_s      = ir_r;
        rep_cnt_s = rep_cnt_r;
        done_s    = 1'b0;
        illegal_s = illegal_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    pc_s      = ZERO_A;
                    rep_cnt_s = ZERO_A;
                    illegal_s = 1'b0;
                    state_s   = ST_FETCH;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_FETCH: state_s = ST_LATCH;
            ST_LATCH: begin
                ir_s    = instr;
                state_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_illegal_s) begin
                    illegal_s = 1'b1;
                end else begin
                    illegal_s = illegal_r;
                end
                // Control-flow and illegal ops always run once and drop any
                // pending repeat; only REP itself reloads the counter.
                if (dec_halt_s) begin
                    rep_cnt_s = ZERO_A;
                    done_s    = 1'b1;
                    state_s   = ST_IDLE;
                end else if (dec_jmp_s) begin
                    rep_cnt_s = ZERO_A;
                    pc_s      = operand_s;
                    state_s   = ST_FETCH;
                end else if (dec_jz_s) begin
                    rep_cnt_s = ZERO_A;
                    pc_s      = y_zero ? operand_s : (pc_r + PC_STEP);
                    state_s   = ST_FETCH;
                end else if (dec_rep_s) begin
                    rep_cnt_s = operand_s;
                    pc_s      = pc_r + PC_STEP;
                    state_s   = ST_FETCH;
                end else if (dec_illegal_s) begin
                    rep_cnt_s = ZERO_A;
                    pc_s      = pc_r + PC_STEP;
                    state_s   = ST_FETCH;
                end else if (rep_cnt_r != ZERO_A) begin
                    // Data op under repeat: reissue without refetching
                    rep_cnt_s = rep_cnt_r - PC_STEP;
                    state_s   = ST_EXEC;
                end else begin
                    pc_s      = pc_r + PC_STEP;
                    state_s   = ST_FETCH;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pc_r      <= ZERO_A;
            ir_r      <= {INSTR_W{1'b0}};
            rep_cnt_r <= ZERO_A;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            ir_r      <= ir_s;
            rep_cnt_r <= rep_cnt_s;
            done_r    <= done_s;
            illegal_r <= illegal_s;
        end
    end

    // Control outputs are the decode of ir, active only while executing
    always_comb begin
        if (state_r == ST_EXEC) begin
            Tx   = dec_tx_s;
            Ty   = dec_ty_s;
            Tz   = dec_tz_s;
            Talu = dec_talu_s;
        end else begin
            Tx   = T_HOLD;
            Ty   = T_HOLD;
            Tz   = T_HOLD;
            Talu = ALU_ADD;
        end
    end

    assign pc      = pc_r;
    assign busy    = (state_r != ST_IDLE);
    assign done    = done_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: an instruction-level model
// expands each program into its expected per-cycle output trace.
module tb_program_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       y_zero;
    logic [7:0] instr;
    logic [3:0] pc;
    logic [1:0] Tx, Ty, Tz;
    logic       Talu, busy, done, illegal;

    logic [7:0] rom [16];
    int         n_checks = 0;
    int         n_fail   = 0;

    // trace record: {pc[13:10], busy[9], done[8], illegal[7], Tx,Ty,Tz,Talu[6:0]}
    typedef logic [13:0] rec_t;
    rec_t exp_q[$];
    bit   exp_halted;

    always #5 clock = ~clock;

    // Synchronous program ROM
    always @(posedge clock) instr <= rom[pc];

    program_sequencer #(.ADDR_W(4), .INSTR_W(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .instr   (instr),
        .y_zero  (y_zero),
        .pc      (pc),
        .Tx      (Tx),
        .Ty      (Ty),
        .Tz      (Tz),
        .Talu    (Talu),
        .busy    (busy),
        .done    (done),
        .illegal (illegal)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controls {Tx,Ty,Tz,Talu} straight from the opcode table
    function automatic logic [6:0] ctl_of(input logic [3:0] op);
        logic [6:0] c;
        case (op)
            4'h1:    c = 7'b01_00_00_0;
            4'h2:    c = 7'b00_01_00_0;
            4'h3:    c = 7'b00_01_00_1;
            4'h4:    c = 7'b00_00_01_0;
            4'h5:    c = 7'b10_10_10_0;
            4'h6:    c = 7'b00_11_00_0;
            default: c = 7'b00_00_00_0;
        endcase
        return c;
    endfunction

    function automatic rec_t mk(input logic [3:0] p, input bit b, input bit d, input bit il, input logic [6:0] c);
        return {p, b, d, il, c};
    endfunction

    // Instruction-level model: 2 overhead cycles + N execute cycles per instruction
    task automatic build_trace(input bit yz, input int max_cycles);
        logic [3:0] mpc;
        logic [3:0] rep;
        logic [3:0] op;
        logic [3:0] opr;
        bit         ill;
        int         n;
        mpc = 4'd0;
        rep = 4'd0;
        ill = 1'b0;
        exp_q.delete();
        exp_halted = 1'b0;
        while (!exp_halted && exp_q.size() < max_cycles) begin
            exp_q.push_back(mk(mpc, 1'b1, 1'b0, ill, 7'd0));
            exp_q.push_back(mk(mpc, 1'b1, 1'b0, ill, 7'd0));
            op  = rom[mpc][7:4];
            opr = rom[mpc][3:0];
            n   = (op <= 4'd6) ? int'(rep) + 1 : 1;
            for (int k = 0; k < n; k++) exp_q.push_back(mk(mpc, 1'b1, 1'b0, ill, ctl_of(op)));
            if (op >= 4'hA && op <= 4'hE) ill = 1'b1;
            rep = (op == 4'h9) ? opr : 4'd0;
            if (op == 4'h7) mpc = opr;
            else if (op == 4'h8) mpc = yz ? opr : mpc + 4'd1;
            else if (op == 4'hF) begin
                exp_halted = 1'b1;
                exp_q.push_back(mk(mpc, 1'b0, 1'b1, ill, 7'd0));
            end
            else mpc = mpc + 4'd1;
        end
        if (exp_q.size() > max_cycles) begin
            while (exp_q.size() > max_cycles) void'(exp_q.pop_back());
            exp_halted = 1'b0;
        end
    endtask

    // Start a program, compare every cycle, reset if it did not halt in budget
    task automatic run_program(input string name, input bit yz, input int max_cycles);
        build_trace(yz, max_cycles);
        y_zero = yz;
        @(negedge clock);
        start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            check_eq($sformatf("%s cyc%0d", name, i),
                     32'({pc, busy, done, illegal, Tx, Ty, Tz, Talu}), 32'(exp_q[i]));
            // start while busy must be ignored
            start = exp_q[i][9] ? 1'($urandom) : 1'b0;
            if (!exp_halted && i == exp_q.size() - 1) reset = 1'b1;
        end
        if (!exp_halted) begin
            @(negedge clock);
            reset = 1'b0;
            start = 1'b0;
            check_eq($sformatf("%s reset", name),
                     32'({pc, busy, done, illegal, Tx, Ty, Tz, Talu}), 32'd0);
        end
        start = 1'b0;
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 16; a++) rom[a] = 8'h00;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        y_zero = 1'b0;
        clear_rom();
        repeat (3) @(negedge clock);
        check_eq("por", 32'({pc, busy, done, illegal, Tx, Ty, Tz, Talu}), 32'd0);
        reset = 1'b0;

        // Reset during EXEC of ADD, then a normal program from address 0
        clear_rom();
        rom[0] = 8'h20;
        run_program("rst_exec", 1'b0, 3);
        rom[0] = 8'h10; rom[1] = 8'h20; rom[2] = 8'h40; rom[3] = 8'hF0;
        run_program("ldx_add_movz", 1'b0, 100);

        // REP 3 then SHRY, HALT fetched at pc 2
        clear_rom();
        rom[0] = 8'h93; rom[1] = 8'h60; rom[2] = 8'hF0;
        run_program("rep_shry", 1'b0, 100);

        // JZ 5 at address 2, both outcomes
        clear_rom();
        rom[2] = 8'h85; rom[3] = 8'hF0; rom[5] = 8'hF0;
        run_program("jz_taken", 1'b1, 100);
        run_program("jz_not", 1'b0, 100);

        // JMP 0 at 15 and NOP wrap at 15 (endless loops, cut by reset)
        clear_rom();
        rom[0] = 8'h7F; rom[15] = 8'h70;
        run_program("jmp15", 1'b0, 20);
        rom[15] = 8'h00;
        run_program("wrap15", 1'b0, 20);

        // Illegal opcode B, then a fresh start clears the flag
        clear_rom();
        rom[0] = 8'hB3; rom[1] = 8'h10; rom[2] = 8'hF0;
        run_program("illegal", 1'b0, 100);
        rom[0] = 8'h00;
        run_program("ill_clear", 1'b0, 100);

        // REP 2 then JMP 9: jump once, repeat dropped
        clear_rom();
        rom[0] = 8'h92; rom[1] = 8'h79; rom[9] = 8'h60; rom[10] = 8'hF0;
        run_program("rep_jmp", 1'b0, 100);

        // Random programs
        for (int r = 0; r < 40; r++) begin
            for (int a = 0; a < 16; a++) rom[a] = 8'($urandom);
            run_program($sformatf("rand%0d", r), 1'($urandom), 120);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
